// File: rtl/jtframe_inputs_pkg.sv
`default_nettype none
// ============================================================================
// Package  : jtframe_inputs_pkg
// Purpose  : Shared PS/2 scan codes, HPS joystick bit indices and the
//            per-player active-high request record.
// Revision : 1.0 - initial release
// ============================================================================
package jtframe_inputs_pkg;

  // PS/2 set-2 scan codes recognised by the mapper
  localparam logic [7:0] c_KEY_UP     = 8'h75;
  localparam logic [7:0] c_KEY_DOWN   = 8'h72;
  localparam logic [7:0] c_KEY_LEFT   = 8'h6B;
  localparam logic [7:0] c_KEY_RIGHT  = 8'h74;
  localparam logic [7:0] c_KEY_BTN0   = 8'h14;
  localparam logic [7:0] c_KEY_BTN1   = 8'h11;
  localparam logic [7:0] c_KEY_BTN2   = 8'h29;
  localparam logic [7:0] c_KEY_BTN3   = 8'h12;
  localparam logic [7:0] c_KEY_START1 = 8'h05;
  localparam logic [7:0] c_KEY_START2 = 8'h06;
  localparam logic [7:0] c_KEY_COIN1  = 8'h04;
  localparam logic [7:0] c_KEY_PAUSE  = 8'h0C;
  localparam logic [7:0] c_KEY_TEST   = 8'h03;

  // Width of one HPS joystick word
  localparam int c_JOY_W = 16;

  // Start/coin/pause sit directly above the fire buttons in the HPS word
  function automatic int joy_start_idx(input int buttons);
    return 4 + buttons;
  endfunction

  function automatic int joy_coin_idx(input int buttons);
    return 5 + buttons;
  endfunction

  function automatic int joy_pause_idx(input int buttons);
    return 6 + buttons;
  endfunction

  // Active-high request for one player; dirs = {up,down,left,right}
  typedef struct packed {
    logic [3:0] dirs;
    logic [3:0] btn;
    logic       start;
    logic       coin;
    logic       pause;
  } req_t;

endpackage
`default_nettype wire

// File: rtl/jtframe_input_player.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_input_player
// Purpose  : Per-player output stage: opposite-direction filter, coin pulse
//            stretcher, button-0 autofire and active-low output registers.
// Revision : 1.0 - initial release
// ============================================================================
module jtframe_input_player
  import jtframe_inputs_pkg::*;
#(
  parameter int BUTTONS     = 2,
  parameter int COIN_W      = 16,
  parameter int AUTOFIRE_W  = 20,
  parameter int NO_OPPOSITE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  req_t                 req_i,
  input  logic                 autofire_en_i,
  output logic [BUTTONS+3:0]   joystick_o,
  output logic                 start_o,
  output logic                 coin_o
);

  localparam logic [COIN_W-1:0]     c_COIN_ONE = {{(COIN_W-1){1'b0}}, 1'b1};
  localparam logic [AUTOFIRE_W-1:0] c_AF_ONE   = {{(AUTOFIRE_W-1){1'b0}}, 1'b1};

  logic [3:0]            w_dirs;
  logic [BUTTONS-1:0]    w_btn_n;
  logic                  w_af_act;

  logic                  coin_prev_q;
  logic [COIN_W-1:0]     coin_cnt_q, coin_cnt_d;
  logic                  af_act_q;
  logic                  af_phase_q, af_phase_d;
  logic [AUTOFIRE_W-1:0] af_cnt_q, af_cnt_d;

  logic [BUTTONS+3:0]    joy_q;
  logic                  start_q, coin_q;

  assign w_af_act = autofire_en_i & req_i.btn[0];

  // Opposite directions cancel each other so the game never sees both
  always_comb begin
    w_dirs = req_i.dirs;
    if (NO_OPPOSITE != 0) begin
      if (req_i.dirs[3] & req_i.dirs[2]) w_dirs[3:2] = 2'b00;
      if (req_i.dirs[1] & req_i.dirs[0]) w_dirs[1:0] = 2'b00;
    end
  end

  // Coin counter: reload on every request rising edge, then run down to 0
  always_comb begin
    coin_cnt_d = coin_cnt_q;
    if (req_i.coin & ~coin_prev_q) begin
      coin_cnt_d = '1;
    end else if (coin_cnt_q != '0) begin
      coin_cnt_d = coin_cnt_q - c_COIN_ONE;
    end
  end

  // Autofire phase: asserted on press, toggles each time the counter wraps
  always_comb begin
    af_phase_d = af_phase_q;
    af_cnt_d   = af_cnt_q;
    if (!w_af_act) begin
      af_phase_d = 1'b0;
      af_cnt_d   = '0;
    end else if (!af_act_q) begin
      af_phase_d = 1'b1;
      af_cnt_d   = '0;
    end else begin
      af_cnt_d = af_cnt_q + c_AF_ONE;
      if (af_cnt_q == '1) af_phase_d = ~af_phase_q;
    end
  end

  // Button 0 is replaced by the autofire phase when autofire is enabled
  always_comb begin
    w_btn_n = ~req_i.btn[BUTTONS-1:0];
    if (autofire_en_i) w_btn_n[0] = ~af_phase_d;
  end

  // State and active-low output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coin_prev_q <= 1'b0;
      coin_cnt_q  <= '0;
      af_act_q    <= 1'b0;
      af_phase_q  <= 1'b0;
      af_cnt_q    <= '0;
      joy_q       <= '1;
      start_q     <= 1'b1;
      coin_q      <= 1'b1;
    end else begin
      coin_prev_q <= req_i.coin;
      coin_cnt_q  <= coin_cnt_d;
      af_act_q    <= w_af_act;
      af_phase_q  <= af_phase_d;
      af_cnt_q    <= af_cnt_d;
      joy_q       <= {w_btn_n, ~w_dirs};
      start_q     <= ~req_i.start;
      coin_q      <= ~(req_i.coin | (coin_cnt_d != '0));
    end
  end

  assign joystick_o = joy_q;
  assign start_o    = start_q;
  assign coin_o     = coin_q;

endmodule
`default_nettype wire

// File: rtl/jtframe_input_mapper.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_input_mapper
// Purpose  : Input front-end between hps_io and the game core: PS/2 key
//            decode, joystick merge, pause toggle and per-player stages.
// Revision : 1.0 - initial release
// ============================================================================
module jtframe_input_mapper
  import jtframe_inputs_pkg::*;
#(
  parameter int PLAYERS     = 2,
  parameter int BUTTONS     = 2,
  parameter int COIN_W      = 16,
  parameter int AUTOFIRE_W  = 20,
  parameter int NO_OPPOSITE = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           soft_rst,
  input  logic [10:0]                    ps2_key,
  input  logic [c_JOY_W*PLAYERS-1:0]     joy_in,
  input  logic [PLAYERS-1:0]             autofire_en,
  output logic [(4+BUTTONS)*PLAYERS-1:0] joystick,
  output logic [PLAYERS-1:0]             start_button,
  output logic [PLAYERS-1:0]             coin_input,
  output logic                           pause,
  output logic                           test
);

  localparam int c_START = joy_start_idx(BUTTONS);
  localparam int c_COIN  = joy_coin_idx(BUTTONS);
  localparam int c_PAUSE = joy_pause_idx(BUTTONS);
  localparam int c_PW    = 4 + BUTTONS;

  logic       tog_q;
  logic [3:0] kdir_q;      // {up,down,left,right}
  logic [3:0] kbtn_q;
  logic [1:0] kstart_q;
  logic       kcoin_q, kpause_q, ktest_q;
  logic       pause_q, pause_req_q, test_q;
  logic       w_ps2_ev, w_pause_req;

  // A flip of the toggle bit marks a new key event
  assign w_ps2_ev = ps2_key[10] ^ tog_q;

  // Key latches follow the pressed flag of each recognised event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog_q    <= 1'b0;
      kdir_q   <= '0;
      kbtn_q   <= '0;
      kstart_q <= '0;
      kcoin_q  <= 1'b0;
      kpause_q <= 1'b0;
      ktest_q  <= 1'b0;
    end else begin
      tog_q <= ps2_key[10];
      if (w_ps2_ev) begin
        case (ps2_key[7:0])
          c_KEY_UP:     kdir_q[3]   <= ps2_key[9];
          c_KEY_DOWN:   kdir_q[2]   <= ps2_key[9];
          c_KEY_LEFT:   kdir_q[1]   <= ps2_key[9];
          c_KEY_RIGHT:  kdir_q[0]   <= ps2_key[9];
          c_KEY_BTN0:   kbtn_q[0]   <= ps2_key[9];
          c_KEY_BTN1:   kbtn_q[1]   <= ps2_key[9];
          c_KEY_BTN2:   kbtn_q[2]   <= ps2_key[9];
          c_KEY_BTN3:   kbtn_q[3]   <= ps2_key[9];
          c_KEY_START1: kstart_q[0] <= ps2_key[9];
          c_KEY_START2: kstart_q[1] <= ps2_key[9];
          c_KEY_COIN1:  kcoin_q     <= ps2_key[9];
          c_KEY_PAUSE:  kpause_q    <= ps2_key[9];
          c_KEY_TEST:   ktest_q     <= ps2_key[9];
          default: ;
        endcase
      end
    end
  end

  // Pause is requested by the keyboard or by any player's pause bit
  always_comb begin
    w_pause_req = kpause_q;
    for (int p = 0; p < PLAYERS; p++) begin
      w_pause_req = w_pause_req | joy_in[c_JOY_W*p + c_PAUSE];
    end
  end

  // Pause toggles on request edges; soft reset clears it and wins over a toggle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pause_q     <= 1'b0;
      pause_req_q <= 1'b0;
      test_q      <= 1'b1;
    end else begin
      pause_req_q <= w_pause_req;
      test_q      <= ~ktest_q;
      if (soft_rst) begin
        pause_q <= 1'b0;
      end else if (w_pause_req & ~pause_req_q) begin
        pause_q <= ~pause_q;
      end
    end
  end

  assign pause = pause_q;
  assign test  = test_q;

  genvar p;
  generate
    for (p = 0; p < PLAYERS; p++) begin : g_player
      req_t w_req;

      // Merge the HPS joystick word with the keyboard (player 1 and starts)
      always_comb begin
        w_req                  = '0;
        w_req.dirs             = joy_in[c_JOY_W*p +: 4];
        w_req.btn[BUTTONS-1:0] = joy_in[c_JOY_W*p+4 +: BUTTONS];
        w_req.start            = joy_in[c_JOY_W*p + c_START];
        w_req.coin             = joy_in[c_JOY_W*p + c_COIN];
        w_req.pause            = joy_in[c_JOY_W*p + c_PAUSE];
        if (p == 0) begin
          w_req.dirs             = w_req.dirs | kdir_q;
          w_req.btn[BUTTONS-1:0] = w_req.btn[BUTTONS-1:0] | kbtn_q[BUTTONS-1:0];
          w_req.start            = w_req.start | kstart_q[0];
          w_req.coin             = w_req.coin | kcoin_q;
        end
        if (p == 1) begin
          w_req.start = w_req.start | kstart_q[1];
        end
      end

      jtframe_input_player #(
        .BUTTONS     (BUTTONS),
        .COIN_W      (COIN_W),
        .AUTOFIRE_W  (AUTOFIRE_W),
        .NO_OPPOSITE (NO_OPPOSITE)
      ) u_player (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (w_req),
        .autofire_en_i (autofire_en[p]),
        .joystick_o    (joystick[c_PW*p +: c_PW]),
        .start_o       (start_button[p]),
        .coin_o        (coin_input[p])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_jtframe_input_mapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtframe_input_mapper
// Purpose  : Self-checking bench: vector table, hand-written corner-case
//            sequences and randomised stimulus against a timestamp model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtframe_input_mapper;

  localparam int P  = 2;
  localparam int B  = 2;
  localparam int CW = 4;
  localparam int AW = 3;
  localparam int JW = (4+B)*P;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          soft_rst = 1'b0;
  logic [10:0]   ps2_key = '0;
  logic [31:0]   joy_in = '0;
  logic [1:0]    autofire_en = '0;

  logic [JW-1:0] joy_a, joy_b;
  logic [1:0]    start_a, start_b, coin_a, coin_b;
  logic          pause_a, pause_b, test_a, test_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jtframe_input_mapper #(
    .PLAYERS(P), .BUTTONS(B), .COIN_W(CW), .AUTOFIRE_W(AW), .NO_OPPOSITE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .ps2_key(ps2_key),
    .joy_in(joy_in), .autofire_en(autofire_en), .joystick(joy_a),
    .start_button(start_a), .coin_input(coin_a), .pause(pause_a), .test(test_a)
  );

  jtframe_input_mapper #(
    .PLAYERS(P), .BUTTONS(B), .COIN_W(CW), .AUTOFIRE_W(AW), .NO_OPPOSITE(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst), .ps2_key(ps2_key),
    .joy_in(joy_in), .autofire_en(autofire_en), .joystick(joy_b),
    .start_button(start_b), .coin_input(coin_b), .pause(pause_b), .test(test_b)
  );

  // ---------------- reference model (event timestamps) ----------------
  logic          mkey [256];
  logic          mtog;
  int            n;
  int            coin_last [2];
  logic          coin_prev [2];
  int            af_start [2];
  logic          af_prev [2];
  logic          mpause, mpause_prev;
  logic [JW-1:0] e_joy_a, e_joy_b;
  logic [1:0]    e_start, e_coin;
  logic          e_pause, e_test;

  task automatic model_reset();
    for (int k = 0; k < 256; k++) mkey[k] = 1'b0;
    mtog = 1'b0;
    n = 0;
    for (int k = 0; k < 2; k++) begin
      coin_last[k] = -1000;
      coin_prev[k] = 1'b0;
      af_start[k]  = 0;
      af_prev[k]   = 1'b0;
    end
    mpause = 1'b0; mpause_prev = 1'b0;
    e_joy_a = '1; e_joy_b = '1; e_start = '1; e_coin = '1;
    e_pause = 1'b0; e_test = 1'b1;
  endtask

  // Expected outputs right after one clock edge, from the pre-edge inputs
  task automatic model_step();
    logic [15:0] jp;
    logic up, dn, lf, rt, b0, b1, st, cn, act, b0n, preq, ud, lr;
    n++;
    preq = mkey[8'h0C];
    for (int p = 0; p < 2; p++) begin
      jp = joy_in[16*p +: 16];
      up = jp[3] | (p == 0 && mkey[8'h75]);
      dn = jp[2] | (p == 0 && mkey[8'h72]);
      lf = jp[1] | (p == 0 && mkey[8'h6B]);
      rt = jp[0] | (p == 0 && mkey[8'h74]);
      b0 = jp[4] | (p == 0 && mkey[8'h14]);
      b1 = jp[5] | (p == 0 && mkey[8'h11]);
      st = jp[6] | (p == 0 && mkey[8'h05]) | (p == 1 && mkey[8'h06]);
      cn = jp[7] | (p == 0 && mkey[8'h04]);
      act = autofire_en[p] & b0;
      if (act && !af_prev[p]) af_start[p] = n;
      af_prev[p] = act;
      if (autofire_en[p])
        b0n = act ? ((((n - af_start[p]) / (1 << AW)) % 2) == 1) : 1'b1;
      else
        b0n = ~b0;
      ud = up & dn;
      lr = lf & rt;
      e_joy_a[6*p +: 6] = {~b1, b0n, ud | ~up, ud | ~dn, lr | ~lf, lr | ~rt};
      e_joy_b[6*p +: 6] = {~b1, b0n, ~up, ~dn, ~lf, ~rt};
      e_start[p] = ~st;
      if (cn && !coin_prev[p]) coin_last[p] = n;
      coin_prev[p] = cn;
      e_coin[p] = ~(cn || ((n - coin_last[p]) < ((1 << CW) - 1)));
      preq = preq | jp[8];
    end
    if (soft_rst) mpause = 1'b0;
    else if (preq && !mpause_prev) mpause = ~mpause;
    mpause_prev = preq;
    e_pause = mpause;
    e_test  = ~mkey[8'h03];
    if (ps2_key[10] != mtog) mkey[ps2_key[7:0]] = ps2_key[9];
    mtog = ps2_key[10];
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic ps2_ev(input logic [7:0] code, input logic pr, input logic ext);
    ps2_key = {~ps2_key[10], pr, ext, code};
  endtask

  task automatic count_coin_low(output int cnt);
    cnt = 0;
    while (coin_a[0] == 1'b0 && cnt < 60) begin
      cnt++;
      tick();
    end
  endtask

  typedef struct {
    logic [31:0]   joy;
    logic [JW-1:0] exp_a;
    logic [JW-1:0] exp_b;
    logic [1:0]    exp_st;
  } vec_t;

  vec_t       tbl [11];
  logic [7:0] codes [16] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h12,
                             8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h00, 8'h55, 8'hF0};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, total;
    tbl[0]  = '{32'h0000_0000, 12'hFFF, 12'hFFF, 2'b11};
    tbl[1]  = '{32'h0000_0001, 12'hFFE, 12'hFFE, 2'b11};
    tbl[2]  = '{32'h0000_000C, 12'hFFF, 12'hFF3, 2'b11};
    tbl[3]  = '{32'h0003_0000, 12'hFFF, 12'hF3F, 2'b11};
    tbl[4]  = '{32'h0000_0020, 12'hFDF, 12'hFDF, 2'b11};
    tbl[5]  = '{32'h0010_0000, 12'hBFF, 12'hBFF, 2'b11};
    tbl[6]  = '{32'h0000_0040, 12'hFFF, 12'hFFF, 2'b10};
    tbl[7]  = '{32'h0040_0000, 12'hFFF, 12'hFFF, 2'b01};
    tbl[8]  = '{32'h0000_000A, 12'hFF5, 12'hFF5, 2'b11};
    tbl[9]  = '{32'h0000_1200, 12'hFFF, 12'hFFF, 2'b11};
    tbl[10] = '{32'h0000_F00F, 12'hFFF, 12'hFF0, 2'b11};

    model_reset();
    // Asynchronous reset, observed before any clock edge
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_joy",   {20'd0, joy_a}, 32'hFFF);
    check("async_rst_coin",  {30'd0, coin_a}, 32'h3);
    check("async_rst_pause", {31'd0, pause_a}, 32'h0);
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    check("rst_joy",   {20'd0, joy_a}, 32'hFFF);
    check("rst_start", {30'd0, start_a}, 32'h3);
    check("rst_coin",  {30'd0, coin_a}, 32'h3);
    check("rst_test",  {31'd0, test_a}, 32'h1);
    check("rst_pause", {31'd0, pause_a}, 32'h0);

    // Steady-state joystick patterns
    for (int i = 0; i < 11; i++) begin
      joy_in = tbl[i].joy;
      tick();
      tick();
      check($sformatf("tbl%0d_joy_a", i), {20'd0, joy_a}, {20'd0, tbl[i].exp_a});
      check($sformatf("tbl%0d_joy_b", i), {20'd0, joy_b}, {20'd0, tbl[i].exp_b});
      check($sformatf("tbl%0d_start", i), {30'd0, start_a}, {30'd0, tbl[i].exp_st});
    end
    joy_in = '0;
    tick();

    // PS/2 up key: two-cycle latency, player 2 untouched
    ps2_ev(8'h75, 1'b1, 1'b0);
    tick();
    check("ps2_up_1clk", {20'd0, joy_a}, 32'hFFF);
    tick();
    check("ps2_up_2clk", {20'd0, joy_a}, 32'hFF7);
    check("ps2_up_p2",   {26'd0, joy_a[11:6]}, 32'h3F);
    ps2_ev(8'h75, 1'b0, 1'b1);
    tick();
    check("ps2_upr_1clk", {20'd0, joy_a}, 32'hFF7);
    tick();
    check("ps2_upr_2clk", {20'd0, joy_a}, 32'hFFF);
    ps2_ev(8'h03, 1'b1, 1'b0);
    tick(); tick();
    check("ps2_test_on", {31'd0, test_a}, 32'h0);
    ps2_ev(8'h03, 1'b0, 1'b0);
    tick(); tick();
    check("ps2_test_off", {31'd0, test_a}, 32'h1);

    // Coin stretch: single pulse, then a retrigger while counting
    joy_in[7] = 1'b1;
    tick();
    joy_in = '0;
    count_coin_low(c1);
    check("coin_single_len", c1, 32'd15);
    repeat (3) tick();
    joy_in[7] = 1'b1;
    tick();
    total = (coin_a[0] == 1'b0) ? 1 : 0;
    joy_in = '0;
    repeat (4) begin
      tick();
      total += (coin_a[0] == 1'b0) ? 1 : 0;
    end
    joy_in[7] = 1'b1;
    tick();
    joy_in = '0;
    count_coin_low(c2);
    check("coin_retrig_len", c2, 32'd15);
    check("coin_total_len", total + c2, 32'd20);

    // Autofire on player-1 button 0
    autofire_en = 2'b01;
    joy_in[4] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      check($sformatf("af_k%0d", k), {31'd0, joy_a[4]}, (((k - 1) / 8) % 2));
    end
    joy_in[4] = 1'b0;
    tick();
    check("af_release", {31'd0, joy_a[4]}, 32'h1);
    joy_in[4] = 1'b1;
    repeat (10) tick();
    check("af_phase_high", {31'd0, joy_a[4]}, 32'h1);
    autofire_en = 2'b00;
    tick();
    check("af_disable_pass", {31'd0, joy_a[4]}, 32'h0);
    joy_in = '0;
    tick();

    // Pause toggle, soft reset priority, F4 key
    joy_in[8] = 1'b1;
    tick();
    check("pause_on", {31'd0, pause_a}, 32'h1);
    joy_in = '0;
    tick();
    check("pause_hold", {31'd0, pause_a}, 32'h1);
    joy_in[8] = 1'b1;
    soft_rst = 1'b1;
    tick();
    check("pause_softrst", {31'd0, pause_a}, 32'h0);
    joy_in = '0;
    soft_rst = 1'b0;
    tick();
    check("pause_after_softrst", {31'd0, pause_a}, 32'h0);
    ps2_ev(8'h0C, 1'b1, 1'b0);
    tick();
    check("pause_f4_1clk", {31'd0, pause_a}, 32'h0);
    tick();
    check("pause_f4_2clk", {31'd0, pause_a}, 32'h1);
    ps2_ev(8'h0C, 1'b0, 1'b0);
    tick(); tick();
    check("pause_f4_release", {31'd0, pause_a}, 32'h1);

    // Randomised run against the model
    ps2_key = '0;
    #1 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) != 0)
        joy_in = ($urandom & $urandom & $urandom & ~32'h0010_0010) | (joy_in & 32'h0010_0010);
      if ($urandom_range(11) == 0) joy_in = joy_in ^ 32'h0000_0010;
      if ($urandom_range(11) == 0) joy_in = joy_in ^ 32'h0010_0000;
      if ($urandom_range(3) == 0)
        ps2_ev(codes[$urandom_range(15)], 1'($urandom_range(1)), 1'($urandom_range(1)));
      soft_rst = ($urandom_range(19) == 0);
      if ($urandom_range(15) == 0) autofire_en = 2'($urandom_range(3));
      tick();
      check("rnd_joy_a", {20'd0, joy_a}, {20'd0, e_joy_a});
      check("rnd_joy_b", {20'd0, joy_b}, {20'd0, e_joy_b});
      check("rnd_start", {30'd0, start_a}, {30'd0, e_start});
      check("rnd_coin",  {30'd0, coin_a}, {30'd0, e_coin});
      check("rnd_pause", {31'd0, pause_a}, {31'd0, e_pause});
      check("rnd_test",  {31'd0, test_a}, {31'd0, e_test});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
